// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way set-associative write-back cache: hit service,
// victim selection, write-back/fill handshake with physical memory, hit/miss counters.

package data_in_mux;
  typedef enum logic {
    cpu_in  = 1'b0,
    pmem_in = 1'b1
  } datainmux_sel_t;
endpackage

package data_out_mux;
  typedef enum logic {
    way0 = 1'b0,
    way1 = 1'b1
  } dataoutmux_sel_t;
endpackage

package mem_address_mux;
  // Way addresses are {1'b0, way}, so the victim bit selects the write-back address directly.
  typedef enum logic [1:0] {
    way0   = 2'b00,
    way1   = 2'b01,
    mem_in = 2'b10
  } memaddressmux_sel_t;
endpackage

package line_out_cpu_mux;
  typedef enum logic {
    way0 = 1'b0,
    way1 = 1'b1
  } lineoutcpumux_sel_t;
endpackage

module cache_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    mem_read,
  input  logic                                    mem_write,
  input  logic                                    hit0,
  input  logic                                    hit1,
  input  logic                                    valid0,
  input  logic                                    valid1,
  input  logic                                    dirty0,
  input  logic                                    dirty1,
  input  logic                                    lru,
  input  logic                                    pmem_resp,
  output logic                                    mem_resp,
  output logic                                    pmem_read,
  output logic                                    pmem_write,
  output logic                                    load_data0,
  output logic                                    load_data1,
  output logic                                    load_tag0,
  output logic                                    load_tag1,
  output logic                                    load_valid0,
  output logic                                    load_valid1,
  output logic                                    load_dirty0,
  output logic                                    load_dirty1,
  output logic                                    valid_in,
  output logic                                    dirty_in,
  output logic                                    lru_in,
  output logic                                    load_lru,
  output data_in_mux::datainmux_sel_t             datainmux_sel,
  output data_out_mux::dataoutmux_sel_t           dataoutmux_sel,
  output mem_address_mux::memaddressmux_sel_t     memaddressmux_sel,
  output line_out_cpu_mux::lineoutcpumux_sel_t    lineoutcpumux_sel,
  output logic [CNT_W-1:0]                        hit_count,
  output logic [CNT_W-1:0]                        miss_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIT_CHECK,
    S_WRITEBACK,
    S_FILL
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_victim;
  logic             w_next_victim;
  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_miss_count;
  logic             w_hit_inc;
  logic             w_miss_inc;

  logic w_req;
  logic w_hit;
  logic w_hit_way;
  logic w_miss_way;
  logic w_miss_dirty;

  assign w_req        = mem_read | mem_write;
  assign w_hit        = hit0 | hit1;
  assign w_hit_way    = ~hit0;
  // Fill an invalid way first; only when both are valid does LRU decide.
  assign w_miss_way   = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru);
  assign w_miss_dirty = w_miss_way ? (valid1 & dirty1) : (valid0 & dirty0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_victim     <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state  <= w_next_state;
      r_victim <= w_next_victim;
      if (w_hit_inc && (r_hit_count != '1))
        r_hit_count <= r_hit_count + CNT_W'(1);
      if (w_miss_inc && (r_miss_count != '1))
        r_miss_count <= r_miss_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_next_state      = r_state;
    w_next_victim     = r_victim;
    w_hit_inc         = 1'b0;
    w_miss_inc        = 1'b0;
    mem_resp          = 1'b0;
    pmem_read         = 1'b0;
    pmem_write        = 1'b0;
    load_data0        = 1'b0;
    load_data1        = 1'b0;
    load_tag0         = 1'b0;
    load_tag1         = 1'b0;
    load_valid0       = 1'b0;
    load_valid1       = 1'b0;
    load_dirty0       = 1'b0;
    load_dirty1       = 1'b0;
    valid_in          = 1'b0;
    dirty_in          = 1'b0;
    lru_in            = 1'b0;
    load_lru          = 1'b0;
    datainmux_sel     = data_in_mux::cpu_in;
    dataoutmux_sel    = data_out_mux::way0;
    memaddressmux_sel = mem_address_mux::mem_in;
    lineoutcpumux_sel = line_out_cpu_mux::way0;

    unique case (r_state)
      S_IDLE: begin
        if (w_req)
          w_next_state = S_HIT_CHECK;
      end

      S_HIT_CHECK: begin
        if (!w_req) begin
          w_next_state = S_IDLE;
        end else if (w_hit) begin
          mem_resp          = 1'b1;
          lineoutcpumux_sel = w_hit_way ? line_out_cpu_mux::way1 : line_out_cpu_mux::way0;
          load_lru          = 1'b1;
          lru_in            = ~w_hit_way;
          if (mem_write) begin
            datainmux_sel = data_in_mux::cpu_in;
            load_data0    = ~w_hit_way;
            load_data1    = w_hit_way;
            load_dirty0   = ~w_hit_way;
            load_dirty1   = w_hit_way;
            dirty_in      = 1'b1;
          end
          w_hit_inc    = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_next_victim = w_miss_way;
          w_miss_inc    = 1'b1;
          w_next_state  = w_miss_dirty ? S_WRITEBACK : S_FILL;
        end
      end

      S_WRITEBACK: begin
        pmem_write        = 1'b1;
        memaddressmux_sel = r_victim ? mem_address_mux::way1 : mem_address_mux::way0;
        dataoutmux_sel    = r_victim ? data_out_mux::way1 : data_out_mux::way0;
        if (pmem_resp)
          w_next_state = S_FILL;
      end

      S_FILL: begin
        pmem_read         = 1'b1;
        memaddressmux_sel = mem_address_mux::mem_in;
        if (pmem_resp) begin
          datainmux_sel = data_in_mux::pmem_in;
          load_data0    = ~r_victim;
          load_data1    = r_victim;
          load_tag0     = ~r_victim;
          load_tag1     = r_victim;
          load_valid0   = ~r_victim;
          load_valid1   = r_victim;
          load_dirty0   = ~r_victim;
          load_dirty1   = r_victim;
          valid_in      = 1'b1;
          dirty_in      = 1'b0;
          w_next_state  = S_HIT_CHECK;
        end
      end

      default: w_next_state = S_IDLE;
    endcase
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_cache_control.sv
// Directed per-cycle vector bench for cache_control; counters built 2 bits wide so
// saturation is reached within the sequences.

module tb_cache_control;

  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rst, mem_read, mem_write, hit0, hit1, valid0, valid1, dirty0, dirty1, lru, pmem_resp;
  logic mem_resp, pmem_read, pmem_write;
  logic load_data0, load_data1, load_tag0, load_tag1, load_valid0, load_valid1;
  logic load_dirty0, load_dirty1, valid_in, dirty_in, lru_in, load_lru;
  data_in_mux::datainmux_sel_t          datainmux_sel;
  data_out_mux::dataoutmux_sel_t        dataoutmux_sel;
  mem_address_mux::memaddressmux_sel_t  memaddressmux_sel;
  line_out_cpu_mux::lineoutcpumux_sel_t lineoutcpumux_sel;
  logic [CW-1:0] hit_count, miss_count;

  cache_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .hit0(hit0), .hit1(hit1), .valid0(valid0), .valid1(valid1),
    .dirty0(dirty0), .dirty1(dirty1), .lru(lru), .pmem_resp(pmem_resp),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .load_data0(load_data0), .load_data1(load_data1),
    .load_tag0(load_tag0), .load_tag1(load_tag1),
    .load_valid0(load_valid0), .load_valid1(load_valid1),
    .load_dirty0(load_dirty0), .load_dirty1(load_dirty1),
    .valid_in(valid_in), .dirty_in(dirty_in), .lru_in(lru_in), .load_lru(load_lru),
    .datainmux_sel(datainmux_sel), .dataoutmux_sel(dataoutmux_sel),
    .memaddressmux_sel(memaddressmux_sel), .lineoutcpumux_sel(lineoutcpumux_sel),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Input flag bits
  localparam int I_RST = 1 << 0, I_RD = 1 << 1, I_WR = 1 << 2, I_H0 = 1 << 3, I_H1 = 1 << 4;
  localparam int I_V0 = 1 << 5, I_V1 = 1 << 6, I_D0 = 1 << 7, I_D1 = 1 << 8, I_LRU = 1 << 9;
  localparam int I_PR = 1 << 10;

  // Output flag bits
  localparam int RESP = 1 << 0, PRD = 1 << 1, PWR = 1 << 2, LD0 = 1 << 3, LD1 = 1 << 4;
  localparam int LT0 = 1 << 5, LT1 = 1 << 6, LV0 = 1 << 7, LV1 = 1 << 8, LDR0 = 1 << 9;
  localparam int LDR1 = 1 << 10, VIN = 1 << 11, DIN = 1 << 12, LRUIN = 1 << 13, LLRU = 1 << 14;
  localparam int DIPM = 1 << 15, DOW1 = 1 << 16, LOW1 = 1 << 17;

  localparam logic [1:0] MA_W0 = 2'b00, MA_W1 = 2'b01, MA_MEM = 2'b10;

  typedef struct {
    string      name;
    int         in;
    int         exp;
    logic [1:0] ma;
    int         hc;
    int         mc;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(string name, int in, int exp, logic [1:0] ma, int hc, int mc);
    vec_t v;
    v.name = name; v.in = in; v.exp = exp; v.ma = ma; v.hc = hc; v.mc = mc;
    vq.push_back(v);
  endfunction

  function automatic int outs();
    int o = 0;
    if (mem_resp)    o |= RESP;
    if (pmem_read)   o |= PRD;
    if (pmem_write)  o |= PWR;
    if (load_data0)  o |= LD0;
    if (load_data1)  o |= LD1;
    if (load_tag0)   o |= LT0;
    if (load_tag1)   o |= LT1;
    if (load_valid0) o |= LV0;
    if (load_valid1) o |= LV1;
    if (load_dirty0) o |= LDR0;
    if (load_dirty1) o |= LDR1;
    if (valid_in)    o |= VIN;
    if (dirty_in)    o |= DIN;
    if (lru_in)      o |= LRUIN;
    if (load_lru)    o |= LLRU;
    if (datainmux_sel == data_in_mux::pmem_in)         o |= DIPM;
    if (dataoutmux_sel == data_out_mux::way1)          o |= DOW1;
    if (lineoutcpumux_sel == line_out_cpu_mux::way1)   o |= LOW1;
    return o;
  endfunction

  task automatic chk(string name, int idx, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(int in);
    rst       = (in & I_RST) != 0;
    mem_read  = (in & I_RD) != 0;
    mem_write = (in & I_WR) != 0;
    hit0      = (in & I_H0) != 0;
    hit1      = (in & I_H1) != 0;
    valid0    = (in & I_V0) != 0;
    valid1    = (in & I_V1) != 0;
    dirty0    = (in & I_D0) != 0;
    dirty1    = (in & I_D1) != 0;
    lru       = (in & I_LRU) != 0;
    pmem_resp = (in & I_PR) != 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int care, act, n, got;

    // Each row is one clock cycle: inputs during the cycle and outputs expected before its edge.
    add("reset_state", 0,                          0, MA_MEM, 0, 0);
    // Read hit on way1
    add("a_idle",      I_RD|I_H1|I_V0|I_V1,        0, MA_MEM, 0, 0);
    add("a_rd_hit1",   I_RD|I_H1|I_V0|I_V1,        RESP|LLRU|LOW1, MA_MEM, 0, 0);
    add("a_after",     0,                          0, MA_MEM, 1, 0);
    // Write hit on way0
    add("b_idle",      I_WR|I_H0|I_V0,             0, MA_MEM, 1, 0);
    add("b_wr_hit0",   I_WR|I_H0|I_V0,             RESP|LLRU|LRUIN|LD0|LDR0|DIN, MA_MEM, 1, 0);
    // Clean miss into invalid way0 (lru=1 must not matter), fill response on 5th cycle
    add("c_idle",      I_RD|I_V1|I_LRU,            0, MA_MEM, 2, 0);
    add("c_miss",      I_RD|I_V1|I_LRU,            0, MA_MEM, 2, 0);
    add("c_fill1",     I_RD|I_V1|I_LRU,            PRD, MA_MEM, 2, 1);
    add("c_fill2",     I_RD|I_V1,                  PRD, MA_MEM, 2, 1);
    add("c_fill3",     I_RD|I_V1|I_LRU,            PRD, MA_MEM, 2, 1);
    add("c_fill4",     I_RD|I_V1,                  PRD, MA_MEM, 2, 1);
    add("c_fill5",     I_RD|I_V1|I_PR,             PRD|DIPM|LD0|LT0|LV0|VIN|LDR0, MA_MEM, 2, 1);
    add("c_retry",     I_RD|I_H0|I_V0|I_V1|I_LRU,  RESP|LLRU|LRUIN, MA_MEM, 2, 1);
    add("c_after",     0,                          0, MA_MEM, 3, 1);
    // Dirty miss: victim way1 via lru, lru flips mid-writeback
    add("d_idle",      I_WR|I_V0|I_V1|I_D1|I_LRU,  0, MA_MEM, 3, 1);
    add("d_miss",      I_WR|I_V0|I_V1|I_D1|I_LRU,  0, MA_MEM, 3, 1);
    add("d_wb1",       I_WR|I_V0|I_V1|I_D1,        PWR|DOW1, MA_W1, 3, 2);
    add("d_wb2",       I_WR|I_V0|I_V1|I_D1|I_PR,   PWR|DOW1, MA_W1, 3, 2);
    add("d_fill1",     I_WR|I_V0|I_V1|I_D1,        PRD, MA_MEM, 3, 2);
    add("d_fill2",     I_WR|I_V0|I_V1|I_D1|I_PR,   PRD|DIPM|LD1|LT1|LV1|VIN|LDR1, MA_MEM, 3, 2);
    add("d_retry",     I_WR|I_H1|I_V0|I_V1,        RESP|LLRU|LOW1|LD1|LDR1|DIN, MA_MEM, 3, 2);
    add("d_after",     0,                          0, MA_MEM, 3, 2);
    // Clean miss into invalid way1 (dirty0 irrelevant), request dropped at retry
    add("e_idle",      I_RD|I_V0|I_D0,             0, MA_MEM, 3, 2);
    add("e_miss",      I_RD|I_V0|I_D0,             0, MA_MEM, 3, 2);
    add("e_fill",      I_RD|I_V0|I_D0|I_PR,        PRD|DIPM|LD1|LT1|LV1|VIN|LDR1, MA_MEM, 3, 3);
    add("e_dropped",   I_H1|I_V0|I_V1,             0, MA_MEM, 3, 3);
    add("e_after",     0,                          0, MA_MEM, 3, 3);
    // Both ways hit: way0 wins
    add("f_idle",      I_RD|I_H0|I_H1|I_V0|I_V1,   0, MA_MEM, 3, 3);
    add("f_both_hit",  I_RD|I_H0|I_H1|I_V0|I_V1,   RESP|LLRU|LRUIN, MA_MEM, 3, 3);
    add("f_after",     0,                          0, MA_MEM, 3, 3);
    // Reset asserted during fill
    add("g_idle",      I_RD,                       0, MA_MEM, 3, 3);
    add("g_miss",      I_RD,                       0, MA_MEM, 3, 3);
    add("g_fill_rst",  I_RD|I_RST,                 PRD, MA_MEM, 3, 3);
    add("g_post_rst",  I_PR,                       0, MA_MEM, 0, 0);
    add("g_stray_pr",  I_PR,                       0, MA_MEM, 0, 0);
    add("g_still_idle",0,                          0, MA_MEM, 0, 0);

    drive(I_RST);
    repeat (2) @(posedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].in);
      #1;
      care = 32'h3FFFF;
      if ((vq[i].exp & (LV0|LV1)) == 0)   care &= ~VIN;
      if ((vq[i].exp & (LDR0|LDR1)) == 0) care &= ~DIN;
      if ((vq[i].exp & LLRU) == 0)        care &= ~LRUIN;
      act = outs();
      chk({vq[i].name, ".outputs"},    i, act & care, vq[i].exp & care);
      chk({vq[i].name, ".mem_addr"},   i, int'(memaddressmux_sel), int'(vq[i].ma));
      chk({vq[i].name, ".hit_count"},  i, int'(hit_count), vq[i].hc);
      chk({vq[i].name, ".miss_count"}, i, int'(miss_count), vq[i].mc);
      chk({vq[i].name, ".pmem_excl"},  i, int'(pmem_read & pmem_write), 0);
    end

    // Clean miss driven by handshake: respond on the 5th pmem_read cycle, bounded wait for mem_resp.
    @(negedge clk);
    drive(I_RD);
    n = 0;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
      if (pmem_read) begin
        n++;
        if (n == 5) begin
          pmem_resp = 1'b1;
          hit0      = 1'b1;
          valid0    = 1'b1;
        end
      end
      if (mem_resp) begin
        got = 1;
        break;
      end
    end
    chk("h_mem_resp_seen", 0, got, 1);
    chk("h_pmem_read_cycles", 0, n, 5);
    chk("h_resp_way0", 0, int'(lineoutcpumux_sel), int'(line_out_cpu_mux::way0));
    @(negedge clk);
    drive(0);
    #1;
    chk("h_hit_count", 0, int'(hit_count), 1);
    chk("h_miss_count", 0, int'(miss_count), 1);
    chk("h_idle_quiet", 0, outs() & (RESP|PRD|PWR|LLRU|LD0|LD1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
